// File: rtl/uart_rx_oversample_if.sv
// Receiver-side signal bundle: serial line and oversampling tick in, recovered byte and status pulses out.
// The o_parity_err member exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversample_if;
    logic       i_rx;
    logic       i_tick;
    logic [7:0] o_data;
    logic       o_flag_rx_done;
    logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;

    modport master (
        input  i_rx, i_tick,
        output o_data, o_flag_rx_done, o_frame_err, o_parity_err
    );
    modport slave (
        output i_rx, i_tick,
        input  o_data, o_flag_rx_done, o_frame_err, o_parity_err
    );
`else
    modport master (
        input  i_rx, i_tick,
        output o_data, o_flag_rx_done, o_frame_err
    );
    modport slave (
        output i_rx, i_tick,
        input  o_data, o_flag_rx_done, o_frame_err
    );
`endif
endinterface

// File: rtl/uart_rx_oversample.sv
// UART receiver: 16x-oversampled, LSB-first, 1 start / SIZE_TRAMA_BIT data / 1 stop.
// Optional parity bit and o_parity_err enabled with UART_RX_PARITY_EN.
module uart_rx_oversample #(
    parameter int SIZE_TRAMA_BIT = 8,
    parameter int TICKS_PER_BIT  = 16,
    parameter int PARITY_ODD     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    uart_rx_oversample_if.master bus
);
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(SIZE_TRAMA_BIT) + 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(SIZE_TRAMA_BIT - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic P_ODD = (PARITY_ODD != 0);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_START  = 6'b000010,
        S_DATA   = 6'b000100,
        S_PARITY = 6'b001000,
        S_STOP   = 6'b010000,
        S_WAIT   = 6'b100000
    } state_t;
`else
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_DATA  = 5'b00100,
        S_STOP  = 5'b01000,
        S_WAIT  = 5'b10000
    } state_t;
`endif

    state_t                    r_state;
    logic                      r_rx_meta;
    logic                      r_rx_s;
    logic [TW-1:0]             r_tick_cnt;
    logic [BW-1:0]             r_bit_cnt;
    logic [SIZE_TRAMA_BIT-1:0] r_sh;
    logic [7:0]                r_data;
    logic                      r_done;
    logic                      r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad;
    logic                      r_parity_err;
`endif

    logic [SIZE_TRAMA_BIT-1:0] w_sh_next;
    logic                      w_mid;
    logic                      w_end;

    // Written as shift-then-patch so a 1-bit frame needs no empty slice.
    always_comb begin
        w_sh_next = r_sh >> 1;
        w_sh_next[SIZE_TRAMA_BIT-1] = r_rx_s;
    end

    assign w_mid = (r_tick_cnt == HALF_M1);
    assign w_end = (r_tick_cnt == FULL_M1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_sh        <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta   <= bus.i_rx;
            r_rx_s      <= r_rx_meta;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (bus.i_tick) begin
                        if (w_mid) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            // A start bit that is high again at its centre was noise.
                            r_state    <= r_rx_s ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.i_tick) begin
                        if (w_end) begin
                            r_sh       <= w_sh_next;
                            r_tick_cnt <= '0;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                r_state   <= S_PARITY;
`else
                                r_state   <= S_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bus.i_tick) begin
                        if (w_end) begin
                            r_par_bad  <= (r_rx_s != (^r_sh ^ P_ODD));
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (bus.i_tick) begin
                        if (w_end) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            if (r_rx_s) begin
                                r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                                if (r_par_bad) begin
                                    r_parity_err <= 1'b1;
                                end else begin
                                    r_data <= 8'(r_sh);
                                    r_done <= 1'b1;
                                end
`else
                                r_data <= 8'(r_sh);
                                r_done <= 1'b1;
`endif
                            end else begin
                                // Frame error wins over parity; a low line must go high before re-arming.
                                r_frame_err <= 1'b1;
                                r_state     <= S_WAIT;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_rx_s) begin
                        r_state    <= S_IDLE;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

    assign bus.o_data         = r_data;
    assign bus.o_flag_rx_done = r_done;
    assign bus.o_frame_err    = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err   = r_parity_err;
`endif

endmodule
